// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the five-step pipeline.
// Latency: load-use and branch responses are combinational; the mult/div freeze holds the front end for MULDIV_CYCLES cycles.
// Backpressure: pc_load/load_step* = 0 hold upstream state; reset_step* = 1 inject bubbles.
//
// Ports:
//   clk, reset                   - pipeline clock, asynchronous active-high reset
//   step2_rs/rt, step2_uses_rt   - source registers of the step2 instruction
//   step3_is_load, step3_rd      - load in step3 and its destination register
//   step3_is_muldiv              - mult/div in step3 (only used with MULDIV_STALL_EN)
//   step3_branch_taken           - branch/jump resolved taken in step3
//   pc_load, load_step1/2        - write enables (0 = hold)
//   reset_step1/2/3              - register clears
//   muldiv_busy                  - high on every mult/div stall cycle
//   stall_cycles                 - saturating count of cycles with pc_load = 0
//
// Build option: define MULDIV_STALL_EN to enable the mult/div freeze FSM.
// Without it, step3_is_muldiv is ignored and muldiv_busy is tied low.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] step2_rs,
    input  logic [REG_ADDR_W-1:0] step2_rt,
    input  logic                  step2_uses_rt,
    input  logic                  step3_is_load,
    input  logic [REG_ADDR_W-1:0] step3_rd,
    input  logic                  step3_is_muldiv,
    input  logic                  step3_branch_taken,
    output logic                  pc_load,
    output logic                  load_step1,
    output logic                  reset_step1,
    output logic                  load_step2,
    output logic                  reset_step2,
    output logic                  reset_step3,
    output logic                  muldiv_busy,
    output logic [15:0]           stall_cycles
);

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    logic load_use_hazard;
    assign load_use_hazard = step3_is_load && (step3_rd != '0) &&
                             ((step3_rd == step2_rs) ||
                              (step2_uses_rt && (step3_rd == step2_rt)));

    logic [15:0] stall_cycles_q, stall_cycles_d;

`ifdef MULDIV_STALL_EN
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MULDIV  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Detection cycle is the first stall cycle, so the counter is loaded with
    // the remaining count minus one more for the cnt==0 exit cycle.
    localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 2);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
`else
    // Mult/div input has no effect in this build.
    logic unused_muldiv;
    assign unused_muldiv = step3_is_muldiv;
`endif

    always_comb begin
        pc_load     = 1'b1;
        load_step1  = 1'b1;
        load_step2  = 1'b1;
        reset_step1 = 1'b0;
        reset_step2 = 1'b0;
        reset_step3 = 1'b0;
        muldiv_busy = 1'b0;
`ifdef MULDIV_STALL_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
`endif

        if (reset) begin
            pc_load     = 1'b0;
            load_step1  = 1'b0;
            load_step2  = 1'b0;
            reset_step1 = 1'b1;
            reset_step2 = 1'b1;
            reset_step3 = 1'b1;
        end else begin
`ifdef MULDIV_STALL_EN
            case (state_q)
                ST_MULDIV: begin
                    // Freeze: branch and load-use inputs are not acted on here.
                    pc_load     = 1'b0;
                    load_step1  = 1'b0;
                    load_step2  = 1'b0;
                    reset_step3 = 1'b1;
                    muldiv_busy = 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_RUN, ST_RELEASE: begin
                    state_d = ST_RUN;
                    if (step3_branch_taken) begin
                        reset_step1 = 1'b1;
                        reset_step2 = 1'b1;
                    end else if (step3_is_muldiv && (state_q == ST_RUN)) begin
                        // RELEASE lets the finished mult/div advance without retriggering.
                        pc_load     = 1'b0;
                        load_step1  = 1'b0;
                        load_step2  = 1'b0;
                        reset_step3 = 1'b1;
                        muldiv_busy = 1'b1;
                        cnt_d       = CNT_LOAD;
                        state_d     = ST_MULDIV;
                    end else if (load_use_hazard) begin
                        pc_load     = 1'b0;
                        load_step1  = 1'b0;
                        reset_step2 = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end
            endcase
`else
            if (step3_branch_taken) begin
                reset_step1 = 1'b1;
                reset_step2 = 1'b1;
            end else if (load_use_hazard) begin
                pc_load     = 1'b0;
                load_step1  = 1'b0;
                reset_step2 = 1'b1;
            end
`endif
        end

        stall_cycles_d = stall_cycles_q;
        if (!reset && !pc_load && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
`ifdef MULDIV_STALL_EN
            state_q        <= ST_RUN;
            cnt_q          <= 8'd0;
`endif
        end else begin
            stall_cycles_q <= stall_cycles_d;
`ifdef MULDIV_STALL_EN
            state_q        <= state_d;
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] step2_rs, step2_rt, step3_rd;
    logic       step2_uses_rt, step3_is_load, step3_is_muldiv, step3_branch_taken;
    logic       pc_load, load_step1, reset_step1, load_step2, reset_step2, reset_step3, muldiv_busy;
    logic [15:0] stall_cycles;

    int total  = 0;
    int passed = 0;
    logic [15:0] exp_stall;

    // Output vector order: pc_load, load_step1, load_step2, reset_step1, reset_step2, reset_step3, muldiv_busy
    localparam logic [6:0] O_DEF = 7'b1110000;
    localparam logic [6:0] O_HAZ = 7'b0010100;
    localparam logic [6:0] O_BR  = 7'b1111100;
    localparam logic [6:0] O_MD  = 7'b0000011;
    localparam logic [6:0] O_RST = 7'b0001110;

    logic [6:0] outs;
    assign outs = {pc_load, load_step1, load_step2, reset_step1, reset_step2, reset_step3, muldiv_busy};

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(4), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .step2_rs(step2_rs), .step2_rt(step2_rt), .step2_uses_rt(step2_uses_rt),
        .step3_is_load(step3_is_load), .step3_rd(step3_rd),
        .step3_is_muldiv(step3_is_muldiv), .step3_branch_taken(step3_branch_taken),
        .pc_load(pc_load), .load_step1(load_step1), .reset_step1(reset_step1),
        .load_step2(load_step2), .reset_step2(reset_step2), .reset_step3(reset_step3),
        .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        step2_rs = 5'd0; step2_rt = 5'd0; step2_uses_rt = 1'b0;
        step3_is_load = 1'b0; step3_rd = 5'd0;
        step3_is_muldiv = 1'b0; step3_branch_taken = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        #1;
        chk("reset_outputs", 32'(outs), 32'(O_RST));
        chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("idle_default", 32'(outs), 32'(O_DEF));
        exp_stall = 16'd0;

        // Load-use on rs
        step3_is_load = 1'b1; step3_rd = 5'd8; step2_rs = 5'd8;
        #1 chk("loaduse_rs", 32'(outs), 32'(O_HAZ));
        tick(); exp_stall = exp_stall + 16'd1;
        chk("stall_cnt_after_hazard", 32'(stall_cycles), 32'(exp_stall));

        // rd = 0 never hazards
        step3_rd = 5'd0; step2_rs = 5'd0;
        #1 chk("loaduse_rd0", 32'(outs), 32'(O_DEF));
        tick();

        // rt gating
        step3_rd = 5'd9; step2_rs = 5'd3; step2_rt = 5'd9; step2_uses_rt = 1'b0;
        #1 chk("rt_unused", 32'(outs), 32'(O_DEF));
        step2_uses_rt = 1'b1;
        #1 chk("rt_used", 32'(outs), 32'(O_HAZ));
        tick(); exp_stall = exp_stall + 16'd1;
        chk("stall_cnt_rt", 32'(stall_cycles), 32'(exp_stall));

        // Branch overrides a simultaneous hazard
        clear_in();
        step3_is_load = 1'b1; step3_rd = 5'd8; step2_rs = 5'd8; step3_branch_taken = 1'b1;
        #1 chk("branch_over_hazard", 32'(outs), 32'(O_BR));
        tick();
        chk("stall_cnt_branch", 32'(stall_cycles), 32'(exp_stall));

        // Mult/div held high
        clear_in();
        step3_is_muldiv = 1'b1;
`ifdef MULDIV_STALL_EN
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                step3_branch_taken = 1'b1;
                step3_is_load = 1'b1; step3_rd = 5'd8; step2_rs = 5'd8;
            end else begin
                step3_branch_taken = 1'b0; step3_is_load = 1'b0;
            end
            #1 chk($sformatf("muldiv_stall_%0d", i), 32'(outs), 32'(O_MD));
            tick(); exp_stall = exp_stall + 16'd1;
        end
        #1 chk("muldiv_release", 32'(outs), 32'(O_DEF));
        chk("stall_cnt_muldiv", 32'(stall_cycles), 32'(exp_stall));
        step3_is_muldiv = 1'b0;
        tick();
        #1 chk("after_release", 32'(outs), 32'(O_DEF));
        chk("stall_cnt_release", 32'(stall_cycles), 32'(exp_stall));

        // Reset mid-stall
        step3_is_muldiv = 1'b1;
        #1 chk("md2_cycle1", 32'(outs), 32'(O_MD));
        tick();
        #1 chk("md2_cycle2", 32'(outs), 32'(O_MD));
        #1 reset = 1'b1;
        #1 chk("async_reset_outputs", 32'(outs), 32'(O_RST));
        chk("async_reset_cnt", 32'(stall_cycles), 32'd0);
        tick();
        reset = 1'b0;
        step3_is_muldiv = 1'b0;
        #1 chk("post_reset_run", 32'(outs), 32'(O_DEF));
        chk("post_reset_cnt", 32'(stall_cycles), 32'd0);
        step3_is_muldiv = 1'b1;
        #1 chk("post_reset_retrigger", 32'(outs), 32'(O_MD));
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        step3_is_muldiv = 1'b0;
`else
        #1 chk("muldiv_ignored", 32'(outs), 32'(O_DEF));
        tick();
        chk("stall_cnt_muldiv", 32'(stall_cycles), 32'(exp_stall));
        step3_is_muldiv = 1'b0;

        // Asynchronous reset while a count is held
        #1 reset = 1'b1;
        #1 chk("async_reset_outputs", 32'(outs), 32'(O_RST));
        chk("async_reset_cnt", 32'(stall_cycles), 32'd0);
        tick();
        reset = 1'b0;
        #1 chk("post_reset_run", 32'(outs), 32'(O_DEF));
        chk("post_reset_cnt", 32'(stall_cycles), 32'd0);
`endif

        // Saturation: hold a load-use hazard
        clear_in();
        #1;
        step3_is_load = 1'b1; step3_rd = 5'd8; step2_rs = 5'd8;
        #1 chk("sat_hazard", 32'(outs), 32'(O_HAZ));
        repeat (65534) @(posedge clk);
        #1 chk("sat_fffe", 32'(stall_cycles), 32'h0000FFFE);
        tick();
        chk("sat_ffff", 32'(stall_cycles), 32'h0000FFFF);
        repeat (10) @(posedge clk);
        #1 chk("sat_hold", 32'(stall_cycles), 32'h0000FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
